// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC helper for the configuration chain loader.
// Holds the FSM state enum, CRC-16-CCITT constants and a one-bit CRC step.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Advance a MSB-first CRC-16 by one serial bit.
    function automatic logic [15:0] crc16_step(
        input logic [15:0] crc,
        input logic        din
    );
        logic fb;
        fb = crc[15] ^ din;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serializer: holds one bitstream word and emits it MSB first.
// Ports: clk/rst_n, clear, pop_en (may emit), accept_en (may take a word),
// cfg_data/cfg_valid/cfg_ready handshake, bits_left, bit_out/bit_valid.
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = 32,
    localparam int BL_W = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              pop_en,
    input  logic              accept_en,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [BL_W-1:0]   bits_left,
    output logic              bit_out,
    output logic              bit_valid
);

    logic [WORD_W-1:0] shreg;
    logic              load;

    assign bit_valid = pop_en && (bits_left != '0);
    assign bit_out   = shreg[WORD_W-1];

    // Taking the next word while the last bit leaves keeps 1 bit/cycle.
    assign cfg_ready = accept_en &&
                       ((bits_left == '0) ||
                        ((bits_left == BL_W'(1)) && bit_valid));

    assign load = cfg_valid && cfg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            bits_left <= '0;
        end else if (clear) begin
            shreg     <= '0;
            bits_left <= '0;
        end else if (load) begin
            shreg     <= cfg_data;
            bits_left <= BL_W'(WORD_W);
        end else if (bit_valid) begin
            shreg     <= {shreg[WORD_W-2:0], 1'b0};
            bits_left <= bits_left - BL_W'(1);
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Parallel-to-serial loader driving ccff_head of the configuration chain.
// Ports: prog_clk, prog_rst_n, start, cfg_data/cfg_valid/cfg_ready,
// ccff_head, ccff_shift_en, ccff_tail, busy, done, bit_count.
// Optional CCFF_TAIL_CRC_EN adds tail_crc, a CRC-16 of ccff_tail.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CHAIN_LEN = 4096,
    localparam int CNT_W = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
`ifdef CCFF_TAIL_CRC_EN
    output logic [15:0]       tail_crc,
`endif
    output logic [CNT_W-1:0]  bit_count
);

    localparam int BL_W = $clog2(WORD_W + 1);

    state_t          state_q;
    state_t          state_d;
    logic            go;
    logic            pop_en;
    logic            accept_en;
    logic [BL_W-1:0] bits_left;
    logic            ser_bit;
    logic            ser_valid;
    logic [31:0]     issued;
    logic [31:0]     committed;

    // A start inside LOAD is ignored.
    assign go = start && (state_q != LOAD);

    // Bits handed to the head so far, including the one on it now.
    assign issued = 32'(bit_count) + 32'(ccff_shift_en);

    // Bits already owned by the loader; no word beyond CHAIN_LEN.
    assign committed = issued + 32'(bits_left);

    assign pop_en    = (state_q == LOAD) && (issued < 32'(CHAIN_LEN));
    assign accept_en = (state_q == LOAD) && (committed < 32'(CHAIN_LEN));

    assign busy = (state_q == LOAD);
    assign done = (state_q == DONE);

    ccff_word_serializer #(
        .WORD_W(WORD_W)
    ) u_ser (
        .clk      (prog_clk),
        .rst_n    (prog_rst_n),
        .clear    (go),
        .pop_en   (pop_en),
        .accept_en(accept_en),
        .cfg_data (cfg_data),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .bits_left(bits_left),
        .bit_out  (ser_bit),
        .bit_valid(ser_valid)
    );

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                if (ccff_shift_en &&
                    (bit_count == CNT_W'(CHAIN_LEN - 1)))
                    state_d = DONE;
            end
            DONE: if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Head holds its value during stalls so the gated chain sees no glitch.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            bit_count     <= '0;
        end else begin
            ccff_shift_en <= ser_valid;
            if (ser_valid) ccff_head <= ser_bit;
            if (go) begin
                bit_count <= '0;
            end else if (ccff_shift_en &&
                         (bit_count != CNT_W'(CHAIN_LEN))) begin
                bit_count <= bit_count + CNT_W'(1);
            end
        end
    end

`ifdef CCFF_TAIL_CRC_EN
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            tail_crc <= CRC16_INIT;
        end else if (go) begin
            tail_crc <= CRC16_INIT;
        end else if (ccff_shift_en) begin
            tail_crc <= crc16_step(tail_crc, ccff_tail);
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Randomized scoreboard bench for ccff_bitstream_loader.
// Two instances: CHAIN_LEN=64 and CHAIN_LEN=40, both WORD_W=32.
module tb_ccff_bitstream_loader;
    import ccff_loader_pkg::*;

    localparam int W = 32;

    logic         clk = 0;
    logic         rst_n = 1;
    logic         start = 0;
    logic         sel = 0;
    logic [W-1:0] cfg_data = '0;
    logic         cfg_valid = 0;
    logic         ccff_tail = 0;

    logic       r64, h64, s64, b64, d64;
    logic [6:0] c64;
    logic       r40, h40, s40, b40, d40;
    logic [5:0] c40;
    logic [15:0] crc64, crc40;

    logic        cur_ready, cur_head, cur_shift, cur_busy, cur_done;
    logic [31:0] cur_bc;
    logic [15:0] cur_crc;

    always #5 clk = ~clk;

    ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(64)) u64 (
        .prog_clk     (clk),
        .prog_rst_n   (rst_n),
        .start        (start & ~sel),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (r64),
        .ccff_head    (h64),
        .ccff_shift_en(s64),
        .ccff_tail    (ccff_tail),
        .busy         (b64),
        .done         (d64),
`ifdef CCFF_TAIL_CRC_EN
        .tail_crc     (crc64),
`endif
        .bit_count    (c64)
    );

    ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(40)) u40 (
        .prog_clk     (clk),
        .prog_rst_n   (rst_n),
        .start        (start & sel),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (r40),
        .ccff_head    (h40),
        .ccff_shift_en(s40),
        .ccff_tail    (ccff_tail),
        .busy         (b40),
        .done         (d40),
`ifdef CCFF_TAIL_CRC_EN
        .tail_crc     (crc40),
`endif
        .bit_count    (c40)
    );

`ifndef CCFF_TAIL_CRC_EN
    assign crc64 = 16'h0;
    assign crc40 = 16'h0;
`endif

    assign cur_ready = sel ? r40 : r64;
    assign cur_head  = sel ? h40 : h64;
    assign cur_shift = sel ? s40 : s64;
    assign cur_busy  = sel ? b40 : b64;
    assign cur_done  = sel ? d40 : d64;
    assign cur_bc    = sel ? 32'(c40) : 32'(c64);
    assign cur_crc   = sel ? crc40 : crc64;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: expected chain bits, pushed when a word is accepted.
    logic         exp_q[$];
    logic [W-1:0] words[$];
    int           nbits;
    int           gaps;
    bit           done_pending;
    logic         last_head;
    logic         exp_bit;
    logic [63:0]  tail_bits = 64'hDEADBEEF_CAFEF00D;
    logic [15:0]  crc_model;

    // Monitor: every enabled cycle must present the next expected bit.
    always @(negedge clk) begin
        if (done_pending) begin
            check("done_after_last_bit", cur_done, 1);
            check("ready_after_last_bit", cur_ready, 0);
            done_pending = 0;
        end
        if (cur_shift) begin
            check("expected_bit_available", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                exp_bit = exp_q.pop_front();
                check("bit_count_during_load", cur_bc, nbits);
                check("ccff_head", cur_head, exp_bit);
                ccff_tail = (nbits < 64) ? tail_bits[63 - nbits] : 1'b0;
                crc_model = crc16_step(crc_model, ccff_tail);
                nbits++;
                if (nbits == (sel ? 40 : 64)) done_pending = 1;
            end
            last_head = cur_head;
        end else if (cur_busy && nbits > 0) begin
            gaps++;
            check("head_held_in_stall", cur_head, last_head);
        end
    end

    // stall_len: >0 fixed stall at each word boundary, 0 none, <0 random.
    task automatic run_load(input bit do_start, input int nw,
                            input int stall_len, input bit mid_start,
                            input int abort_bits);
        int idx, cyc, pushed, chain, stall_left, stalled_idx;
        int total_stall, len;
        bit aborted;
        idx = 0; cyc = 0; pushed = 0; stall_left = 0;
        stalled_idx = -1; total_stall = 0; aborted = 0;
        chain = sel ? 40 : 64;
        exp_q.delete();
        nbits = 0; gaps = 0; done_pending = 0;
        crc_model = CRC16_INIT;
        if (do_start) begin
            @(negedge clk); start = 1;
            @(negedge clk); start = 0;
        end
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cur_done) break;
            if (abort_bits > 0 && nbits >= abort_bits) begin
                aborted = 1;
                break;
            end
            start = mid_start && (nbits == 10);
            if (stall_left > 0) begin
                cfg_valid = 0;
                stall_left--;
            end else if (idx < nw) begin
                len = (stall_len < 0) ? int'($urandom_range(0, 4))
                                      : stall_len;
                if (cur_ready && idx > 0 && stalled_idx != idx && len > 0) begin
                    stalled_idx = idx;
                    stall_left = len - 1;
                    total_stall += len;
                    cfg_valid = 0;
                end else begin
                    cfg_valid = 1;
                    cfg_data = words[idx];
                    if (cur_ready) begin
                        for (int b = W - 1; b >= 0; b--) begin
                            if (pushed < chain) begin
                                exp_q.push_back(words[idx][b]);
                                pushed++;
                            end
                        end
                        idx++;
                    end
                end
            end else begin
                cfg_valid = 0;
            end
        end
        start = 0;
        if (!aborted) begin
            check("load_done", cur_done, 1);
            check("final_bit_count", cur_bc, chain);
            check("shift_cycles", nbits, chain);
            check("stall_gap_cycles", gaps, total_stall);
            check("words_accepted", idx, (chain + W - 1) / W);
            check("scoreboard_drained", exp_q.size(), 0);
`ifdef CCFF_TAIL_CRC_EN
            check("tail_crc", cur_crc, crc_model);
`endif
            for (int k = 0; k < 3; k++) begin
                cfg_valid = 1;
                cfg_data = $urandom;
                check("ready_in_done", cur_ready, 0);
                check("done_held", cur_done, 1);
                @(negedge clk);
            end
        end
        cfg_valid = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, cur_ready, 0);
        check({tag, "_head"}, cur_head, 0);
        check({tag, "_shift_en"}, cur_shift, 0);
        check({tag, "_busy"}, cur_busy, 0);
        check({tag, "_done"}, cur_done, 0);
        check({tag, "_bit_count"}, cur_bc, 0);
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    initial begin
        #1 rst_n = 0;
        #3;
        check_reset_outputs("reset");
`ifdef CCFF_TAIL_CRC_EN
        check("reset_tail_crc", cur_crc, CRC16_INIT);
`endif
        @(negedge clk);
        rst_n = 1;

        // Basic contiguous load.
        sel = 0;
        words.delete();
        words.push_back(32'hA5A5_0000);
        words.push_back(32'h0000_FFFF);
        words.push_back(32'h1234_5678);
        run_load(1, 3, 0, 0, 0);

        // Fixed 5-cycle stall between words.
        rand_words(3);
        run_load(1, 3, 5, 0, 0);

        // Partial final word on the 40-bit chain.
        sel = 1;
        words.delete();
        words.push_back(32'hFFFF_FFFF);
        words.push_back(32'hF0FF_FFFF);
        words.push_back(32'h0F0F_0F0F);
        run_load(1, 3, 0, 0, 0);
        rand_words(3);
        run_load(1, 3, -1, 1, 0);

        // Random stalls plus an ignored start during LOAD.
        sel = 0;
        for (int r = 0; r < 4; r++) begin
            rand_words(3);
            run_load(1, 3, -1, 1, 0);
        end

        // Reset in the middle of a load, then a full reload.
        rand_words(3);
        run_load(1, 3, 0, 0, 20);
        #2 rst_n = 0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        rand_words(3);
        run_load(1, 3, -1, 0, 0);

        // Start from DONE clears done and bit_count on the next cycle.
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        check("restart_done_clear", cur_done, 0);
        check("restart_bit_count", cur_bc, 0);
        check("restart_busy", cur_busy, 1);
        rand_words(3);
        run_load(0, 3, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
